// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
package shift_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..31 positions in the selected mode.
// Rotate support is present only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [4:0]        k,
  input  logic [1:0]        mode,
  output logic [WORD_W-1:0] y
);

`ifdef SHIFT_ROTATE_EN
  logic [2*WORD_W-1:0] dbl;
`endif

  always_comb begin
    y = a >> k;
`ifdef SHIFT_ROTATE_EN
    dbl = {a, a} >> k;
`endif
    if (mode == OP_SRA) begin
      y = WORD_W'($signed(a) >>> k);
    end
`ifdef SHIFT_ROTATE_EN
    else if (mode == OP_ROR) begin
      y = dbl[WORD_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential right shifter: moves up to STEP bit positions per RUN cycle.
// Rotate mode is enabled by defining SHIFT_ROTATE_EN.
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] tbsh,
  input  logic [WORD_W-1:0] s,
  input  logic [1:0]        op,
  output logic [WORD_W-1:0] sh,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t            state, state_nx;
  logic [WORD_W-1:0] work, work_nx, sh_nx, step_y;
  logic [4:0]        rem, rem_nx, k;
  logic [1:0]        mode, mode_nx;
  logic              unused_s_hi;

  assign unused_s_hi = ^s[WORD_W-1:5];

  assign k = (rem < STEP_K) ? rem : STEP_K;

  shift_step u_step (
    .a    (work),
    .k    (k),
    .mode (mode),
    .y    (step_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      mode  <= OP_SRL;
      sh    <= '0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      rem   <= rem_nx;
      mode  <= mode_nx;
      sh    <= sh_nx;
    end
  end

  always_comb begin
    state_nx = state;
    work_nx  = work;
    rem_nx   = rem;
    mode_nx  = mode;
    sh_nx    = sh;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          state_nx = RUN;
          work_nx  = tbsh;
          rem_nx   = s[4:0];
          mode_nx  = op;
        end
      end
      RUN: begin
        work_nx = step_y;
        rem_nx  = rem - k;
        // A zero count still spends this one cycle, so the exit test is on rem <= STEP.
        if (rem <= STEP_K) begin
          state_nx = DONE;
          sh_nx    = step_y;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL have parameter STEP, default 4, giving the maximum bit positions shifted per RUN cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request a new shift; sampled only in IDLE or DONE.
REQ-005 SHALL have port tbsh, input, 32, the operand to be shifted.
REQ-006 SHALL have port s, input, 32, the shift amount; only s[4:0] is used and s[31:5] is ignored.
REQ-007 SHALL have port op, input, 2, the mode: 2'b00 logical right (SRL), 2'b01 arithmetic right (SRA), 2'b10 rotate right (ROR), 2'b11 reserved and treated as SRL.
REQ-008 SHALL have port sh, output, 32, the result register.
REQ-009 SHALL have port busy, output, 1, high while in RUN.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking sh valid.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE with these transitions:
- IDLE to RUN on start.
- RUN to DONE when the remaining count reaches 0.
- DONE to RUN on start.
- DONE to IDLE otherwise.
REQ-012 On an accepted start, SHALL latch tbsh into the working register, s[4:0] into a 5-bit remaining count, and op into the mode register.
REQ-013 In each RUN cycle, SHALL shift the working register right by k = min(remaining, STEP) and decrement remaining by k.
REQ-014 Bits shifted in at the top SHALL be:
- zeros for SRL;
- copies of the latched bit 31 for SRA;
- the bits shifted out at the bottom for ROR.
REQ-015 Latency SHALL be max(1, ceil(s[4:0]/STEP)) RUN cycles; done SHALL be high in the cycle immediately after the last RUN edge.
REQ-016 A shift amount of 0 SHALL take exactly one RUN cycle and return tbsh unchanged.
REQ-017 s = 32 SHALL behave as shift 0, because only s[4:0] is used.
REQ-018 sh SHALL update only on the edge entering DONE, and SHALL hold its value until the next completion.
REQ-019 start while busy SHALL be ignored: no queueing, and the in-flight operation is not disturbed.
REQ-020 Input changes after the start edge SHALL NOT affect the in-flight result.
REQ-021 start asserted during the DONE cycle SHALL be accepted (back-to-back operation); done SHALL then go low the next cycle.

Reset
REQ-022 With rst_n low at a clock edge, SHALL go to IDLE with sh = 32'h0, busy = 0, done = 0, remaining count = 0.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-024 start SHALL be ignored on any edge where rst_n is low.

Configuration
REQ-025 Macro SHIFT_ROTATE_EN SHALL control ROR support.
- Defined: op 2'b10 performs rotate right.
- Undefined: op 2'b10 SHALL behave exactly as SRL and no rotate logic is synthesised.
REQ-026 All other behaviour SHALL be identical in both configurations.

Structure
REQ-027 Package shift_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the op encodings OP_SRL, OP_SRA, OP_ROR;
- the constant WORD_W = 32.
REQ-028 SHALL instantiate one combinational sub-module, shift_step. It takes the operand, k (0..STEP) and the mode, and returns the operand shifted by k; the FSM and registers stay in shift_right_seq.

Verification
REQ-029 tbsh = 32'h80000000, s = 31, op = SRL, STEP = 4 -> busy for 8 cycles, then sh = 32'h00000001 with done high for 1 cycle.
REQ-030 tbsh = 32'h80000000, s = 4, op = SRA -> 1 RUN cycle, then sh = 32'hF8000000.
REQ-031 tbsh = 32'h12345678, s = 32 and, separately, s = 0 -> 1 RUN cycle each, sh = 32'h12345678.
REQ-032 tbsh = 32'h0000000F, s = 4, op = 2'b10 -> sh = 32'hF0000000 with SHIFT_ROTATE_EN defined; sh = 32'h00000000 without it.
REQ-033 A second start during RUN with a different operand -> ignored; the first result is delivered. A start in the DONE cycle -> the second result is delivered with no idle gap.
REQ-034 rst_n low for 1 cycle mid-RUN (s = 20) -> next cycle sh = 0, busy = 0, and no done pulse.
